// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: owns the single GRF write port and shares it between
// the W stage and a long-latency unit whose results arrive out of band.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pipe_we/waddr/wdata W-stage write request
//   lu_valid/ready      long-latency result handshake (FIFO push)
//   lu_waddr/wdata      long-latency result destination and data
//   iss_lu/iss_waddr    long-latency op issued, and its destination
//   dec_rs/rt/we/rd     D-stage operands and destination
//   stall               D-stage hazard on a pending register
//   pipe_hold           one-cycle freeze when buffered results starve
//   grf_we/waddr/wdata  GRF write port
//
// Optional macro GRF_WB_BYPASS_EN: grant a long-latency result straight
// to the GRF when the FIFO is empty and the pipeline is not writing.

module grf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic        iss_lu,
    input  logic [4:0]  iss_waddr,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic        dec_we,
    input  logic [4:0]  dec_rd,
    output logic        stall,
    output logic        pipe_hold,
    output logic        grf_we,
    output logic [4:0]  grf_waddr,
    output logic [31:0] grf_wdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [SW-1:0] STV_LAST = SW'(STARVE_LIMIT - 1);

    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic [CNT_W-1:0] pend [32];
    logic [SW-1:0]    starve;

    logic        empty;
    logic        full;
    logic        pipe_eff;
    logic        pipe_gnt;
    logic        fifo_gnt;
    logic        byp_gnt;
    logic        lu_commit;
    logic        push;
    logic        pop;
    logic        inc;
    logic        dec;
    logic [4:0]  cm_addr;
    logic [31:0] cm_data;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign lu_ready = !full && !reset;

    always_comb begin
        pipe_eff = pipe_we && (pipe_waddr != 5'd0);
        // During pipe_hold the W-stage request is a replay; ignore it.
        fifo_gnt = !reset && !empty && (pipe_hold || !pipe_eff);
        pipe_gnt = !reset && !pipe_hold && pipe_eff;
`ifdef GRF_WB_BYPASS_EN
        byp_gnt  = empty && !pipe_gnt && lu_valid && lu_ready;
`else
        byp_gnt  = 1'b0;
`endif
        lu_commit = fifo_gnt || byp_gnt;
        push      = lu_valid && lu_ready && !byp_gnt;
        pop       = fifo_gnt;
        cm_addr   = fifo_gnt ? fifo_addr[rd_ptr] : lu_waddr;
        cm_data   = fifo_gnt ? fifo_data[rd_ptr] : lu_wdata;
        inc       = iss_lu && (iss_waddr != 5'd0);
        dec       = lu_commit && (cm_addr != 5'd0);
    end

    // Entries for $0 are consumed without touching the port.
    always_comb begin
        grf_we    = 1'b0;
        grf_waddr = 5'd0;
        grf_wdata = 32'd0;
        unique case (1'b1)
            pipe_gnt: begin
                grf_we    = 1'b1;
                grf_waddr = pipe_waddr;
                grf_wdata = pipe_wdata;
            end
            dec: begin
                grf_we    = 1'b1;
                grf_waddr = cm_addr;
                grf_wdata = cm_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lu_waddr;
            fifo_data[wr_ptr] <= lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Issue and commit of the same register in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++)
                pend[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc && iss_waddr == 5'(r) &&
                    !(dec && cm_addr == 5'(r)))
                    pend[r] <= pend[r] + 1'b1;
                else if (dec && cm_addr == 5'(r) &&
                         !(inc && iss_waddr == 5'(r)))
                    pend[r] <= pend[r] - 1'b1;
            end
        end
    end

    always_comb begin
        stall = ((dec_rs != 5'd0) && (pend[dec_rs] != '0)) ||
                ((dec_rt != 5'd0) && (pend[dec_rt] != '0)) ||
                (dec_we && (dec_rd != 5'd0) && (pend[dec_rd] != '0));
    end

    // The hold cycle always pops the FIFO head, so pipe_hold self-clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve    <= '0;
            pipe_hold <= 1'b0;
        end else if (empty || pop) begin
            starve    <= '0;
            pipe_hold <= 1'b0;
        end else if (starve == STV_LAST) begin
            starve    <= '0;
            pipe_hold <= 1'b1;
        end else begin
            starve    <= starve + 1'b1;
            pipe_hold <= 1'b0;
        end
    end

endmodule
